// File: rtl/section_input_if.sv
// rtl/section_input_if.sv - USRT receiver strobe, serial data, consumer handshake and status bundle
interface section_input_if;
   logic       usrt_pedge;
   logic       size_flag;
   logic       rts;
   logic       rxd;
   logic       rd_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic       pattern_err;

   modport master (
      output usrt_pedge, size_flag, rts, rxd, rd_ack,
      input  rx_data, rx_valid, frame_err, overrun, busy, pattern_err
   );

   modport slave (
      input  usrt_pedge, size_flag, rts, rxd, rd_ack,
      output rx_data, rx_valid, frame_err, overrun, busy, pattern_err
   );
endinterface

// File: rtl/section_input.sv
// rtl/section_input.sv - USRT frame receiver: start/7-or-8 data/2 stop bits, sticky status flags
// Optional alternating all-0/all-1 data pattern check when RX_PATTERN_CHECK_EN is defined.
module section_input (
   input  logic            clk,
   input  logic            rst,
   section_input_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, DATA, STOP1, STOP2} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       sample;
   logic       start_hit;
   logic [3:0] bit_cnt;
   logic [7:0] shift_reg;
   logic       size_lat;
   logic       stop_err;

   logic       done;
   logic       done_good;
   logic [7:0] done_data;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       set_valid;
   logic       set_ovr;
   logic       set_ferr;

   assign sample = bus.usrt_pedge;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_hit = 1'b0;
      case (state)
         IDLE: begin
            if (sample && bus.rts && !bus.rxd) begin
               state_nxt = DATA;
               start_hit = 1'b1;
            end
         end
         DATA: begin
            if (sample && bit_cnt == (size_lat ? 4'd7 : 4'd6)) state_nxt = STOP1;
         end
         STOP1: if (sample) state_nxt = STOP2;
         STOP2: if (sample) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bits are written by index so bit 7 stays cleared in 7-bit mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= 4'd0;
         shift_reg <= 8'h00;
         size_lat  <= 1'b0;
         stop_err  <= 1'b0;
         done      <= 1'b0;
         done_good <= 1'b0;
         done_data <= 8'h00;
      end else begin
         done <= 1'b0;
         if (start_hit) begin
            size_lat  <= bus.size_flag;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            stop_err  <= 1'b0;
         end
         if (sample) begin
            case (state)
               DATA: begin
                  shift_reg[bit_cnt[2:0]] <= bus.rxd;
                  bit_cnt                 <= bit_cnt + 4'd1;
               end
               STOP1: stop_err <= ~bus.rxd;
               STOP2: begin
                  done      <= 1'b1;
                  done_good <= ~stop_err & bus.rxd;
                  done_data <= shift_reg;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      set_valid = done && done_good && (!rx_valid || bus.rd_ack);
      set_ovr   = done && done_good && rx_valid && !bus.rd_ack;
      set_ferr  = done && !done_good;
   end

   // rd_ack clears the sticky flags, but a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (set_valid) rx_data <= done_data;
         rx_valid  <= set_valid | (rx_valid & ~bus.rd_ack);
         frame_err <= set_ferr  | (frame_err & ~bus.rd_ack);
         overrun   <= set_ovr   | (overrun & ~bus.rd_ack);
      end
   end

`ifdef RX_PATTERN_CHECK_EN
   logic       done_size;
   logic       hist_valid;
   logic       hist_level;
   logic       pattern_err;
   logic [7:0] pat_mask;
   logic       all_zero;
   logic       all_one;
   logic       set_pat;

   always_ff @(posedge clk) begin
      if (rst)                           done_size <= 1'b0;
      else if (sample && state == STOP2) done_size <= size_lat;
   end

   always_comb begin
      pat_mask = done_size ? 8'hFF : 8'h7F;
      all_zero = (done_data & pat_mask) == 8'h00;
      all_one  = (done_data & pat_mask) == pat_mask;
      set_pat  = done && done_good &&
                 (!(all_zero || all_one) || (hist_valid && hist_level == all_one));
   end

   // History only advances on uniform frames; dropped (overrun) frames count too.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_valid  <= 1'b0;
         hist_level  <= 1'b0;
         pattern_err <= 1'b0;
      end else begin
         pattern_err <= set_pat | (pattern_err & ~bus.rd_ack);
         if (done && done_good && (all_zero || all_one)) begin
            hist_valid <= 1'b1;
            hist_level <= all_one;
         end
      end
   end

   assign bus.pattern_err = pattern_err;
`else
   assign bus.pattern_err = 1'b0;
`endif

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_section_input.sv
// tb/tb_section_input.sv - self-checking bench for section_input; honours RX_PATTERN_CHECK_EN
module tb_section_input;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   section_input_if bus();
   section_input dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Model holds the outputs expected after the next rising edge.
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_pat = 1'b0, m_busy = 1'b0;
   logic       pend = 1'b0, pend_good = 1'b0, pend_size = 1'b0;
   logic [7:0] pend_data = 8'h00;
   logic       hist_v = 1'b0, hist_lvl = 1'b0;
   logic       want_rts = 1'b1, want_size = 1'b1;
   logic       run = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (run) begin
         chk("rx_data", bus.rx_data, m_data);
         chk("rx_valid", {7'd0, bus.rx_valid}, {7'd0, m_valid});
         chk("frame_err", {7'd0, bus.frame_err}, {7'd0, m_ferr});
         chk("overrun", {7'd0, bus.overrun}, {7'd0, m_ovr});
         chk("busy", {7'd0, bus.busy}, {7'd0, m_busy});
         chk("pattern_err", {7'd0, bus.pattern_err}, {7'd0, m_pat});
      end
   end

   function automatic logic pattern_fail(input logic [7:0] v, input logic sz);
      logic fail;
      fail = 1'b0;
`ifdef RX_PATTERN_CHECK_EN
      begin
         int ones;
         int width;
         logic uniform;
         logic lvl;
         ones    = $countones(v);
         width   = sz ? 8 : 7;
         uniform = (ones == 0) || (ones == width);
         lvl     = (ones != 0);
         fail    = !uniform || (hist_v && hist_lvl == lvl);
         if (uniform) begin
            hist_v   = 1'b1;
            hist_lvl = lvl;
         end
      end
`endif
      return fail;
   endfunction

   task automatic step(input logic pe, input logic d, input logic ack);
      logic sv, so, sf, sp;
      @(negedge clk);
      rst = 1'b0;
      bus.usrt_pedge = pe;
      bus.rxd = d;
      bus.rd_ack = ack;
      bus.rts = want_rts;
      bus.size_flag = want_size;
      sv = 1'b0; so = 1'b0; sf = 1'b0; sp = 1'b0;
      if (pend) begin
         pend = 1'b0;
         if (pend_good) begin
            if (!m_valid || ack) begin
               m_data = pend_data;
               sv = 1'b1;
            end else begin
               so = 1'b1;
            end
            sp = pattern_fail(pend_data, pend_size);
         end else begin
            sf = 1'b1;
         end
      end
      if (ack) begin
         m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_pat = 1'b0;
      end
      if (sv) m_valid = 1'b1;
      if (so) m_ovr = 1'b1;
      if (sf) m_ferr = 1'b1;
      if (sp) m_pat = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic ack();
      step(1'b0, 1'b1, 1'b1);
   endtask

   // Reset is asserted together with a start-bit sample and rd_ack to show it wins.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.usrt_pedge = 1'b1;
      bus.rxd = 1'b0;
      bus.rd_ack = 1'b1;
      bus.rts = 1'b1;
      m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_pat = 1'b0; m_busy = 1'b0;
      pend = 1'b0; hist_v = 1'b0; hist_lvl = 1'b0;
      run = 1'b1;
   endtask

   task automatic send_frame(input logic sz, input logic [7:0] data, input logic s1, input logic s2,
                             input int drop_at, input logic ack_done);
      int n;
      n = sz ? 8 : 7;
      want_rts = 1'b1;
      want_size = sz;
      step(1'b1, 1'b0, 1'b0);
      m_busy = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         step(1'b1, data[i], 1'b0);
         if (i == drop_at) want_rts = 1'b0;
         step(1'b0, 1'b1, 1'b0);
      end
      step(1'b1, s1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, s2, 1'b0);
      m_busy = 1'b0;
      pend = 1'b1;
      pend_good = s1 & s2;
      pend_data = sz ? data : {1'b0, data[6:0]};
      pend_size = sz;
      if (ack_done) ack();
   endtask

   initial begin
      bus.usrt_pedge = 1'b0;
      bus.rxd = 1'b1;
      bus.rts = 1'b1;
      bus.size_flag = 1'b1;
      bus.rd_ack = 1'b0;
      repeat (2) @(negedge clk);

      do_reset();
      idle(2);
      chk("reset_data", bus.rx_data, 8'h00);
      chk("reset_valid", {7'd0, bus.rx_valid}, 8'h00);
      chk("reset_busy", {7'd0, bus.busy}, 8'h00);
      chk("reset_pattern", {7'd0, bus.pattern_err}, 8'h00);

      // 8-bit all-zero frame and its one-clock output latency
      send_frame(1'b1, 8'h00, 1'b1, 1'b1, -1, 1'b0);
      idle(1);
      chk("lat_pre_valid", {7'd0, bus.rx_valid}, 8'h00);
      idle(1);
      chk("lat_post_valid", {7'd0, bus.rx_valid}, 8'h01);
      chk("zero_data", bus.rx_data, 8'h00);
      chk("zero_ferr", {7'd0, bus.frame_err}, 8'h00);
      ack();

      // 7-bit frame then an unread second frame -> overrun, first data kept
      send_frame(1'b0, 8'hFF, 1'b1, 1'b1, -1, 1'b0);
      send_frame(1'b0, 8'h15, 1'b1, 1'b1, -1, 1'b0);
      idle(2);
      chk("ovr_data", bus.rx_data, 8'h7F);
      chk("ovr_flag", {7'd0, bus.overrun}, 8'h01);
      ack();
      idle(1);
      chk("ovr_cleared", {7'd0, bus.overrun}, 8'h00);

      // bad stop bit leaves earlier data intact
      send_frame(1'b1, 8'h5A, 1'b1, 1'b1, -1, 1'b0);
      send_frame(1'b1, 8'hFF, 1'b0, 1'b1, -1, 1'b0);
      idle(2);
      chk("ferr_flag", {7'd0, bus.frame_err}, 8'h01);
      chk("ferr_data", bus.rx_data, 8'h5A);
      chk("ferr_valid", {7'd0, bus.rx_valid}, 8'h01);
      ack();
      idle(1);
      chk("ferr_cleared", {7'd0, bus.frame_err}, 8'h00);

      // rd_ack in the load cycle lets a new frame replace a pending one
      send_frame(1'b1, 8'hA5, 1'b1, 1'b1, -1, 1'b0);
      idle(1);
      send_frame(1'b1, 8'h3C, 1'b1, 1'b1, -1, 1'b1);
      idle(1);
      chk("ackload_data", bus.rx_data, 8'h3C);
      chk("ackload_valid", {7'd0, bus.rx_valid}, 8'h01);
      chk("ackload_ovr", {7'd0, bus.overrun}, 8'h00);
      ack();

      // rts low gates start detection; rts falling mid-frame does not abort
      want_rts = 1'b0;
      for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0);
      idle(1);
      chk("rts_low_busy", {7'd0, bus.busy}, 8'h00);
      chk("rts_low_valid", {7'd0, bus.rx_valid}, 8'h00);
      send_frame(1'b1, 8'hC3, 1'b1, 1'b1, 2, 1'b0);
      idle(2);
      chk("rts_drop_data", bus.rx_data, 8'hC3);

      // reset after four data bits, then a clean 0xFF frame
      want_rts = 1'b1;
      want_size = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      m_busy = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0);
      do_reset();
      idle(1);
      chk("midrst_busy", {7'd0, bus.busy}, 8'h00);
      chk("midrst_valid", {7'd0, bus.rx_valid}, 8'h00);
      chk("midrst_data", bus.rx_data, 8'h00);
      send_frame(1'b1, 8'hFF, 1'b1, 1'b1, -1, 1'b0);
      idle(2);
      chk("post_rst_data", bus.rx_data, 8'hFF);
      ack();

      // back-to-back frames with start on the sample right after STOP2
      send_frame(1'b1, 8'h81, 1'b1, 1'b1, -1, 1'b0);
      send_frame(1'b1, 8'h42, 1'b1, 1'b1, -1, 1'b0);
      idle(2);
      chk("b2b_data", bus.rx_data, 8'h81);
      chk("b2b_ovr", {7'd0, bus.overrun}, 8'h01);
      ack();

`ifdef RX_PATTERN_CHECK_EN
      do_reset();
      idle(1);
      send_frame(1'b1, 8'h00, 1'b1, 1'b1, -1, 1'b0);
      ack();
      send_frame(1'b1, 8'hFF, 1'b1, 1'b1, -1, 1'b0);
      idle(2);
      chk("pat_alt_ok", {7'd0, bus.pattern_err}, 8'h00);
      ack();
      send_frame(1'b1, 8'hFF, 1'b1, 1'b1, -1, 1'b0);
      idle(2);
      chk("pat_repeat", {7'd0, bus.pattern_err}, 8'h01);
      ack();
      idle(1);
      chk("pat_cleared", {7'd0, bus.pattern_err}, 8'h00);
      send_frame(1'b1, 8'h0F, 1'b1, 1'b1, -1, 1'b0);
      idle(2);
      chk("pat_mixed", {7'd0, bus.pattern_err}, 8'h01);
      ack();
`endif

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/section_input.md
SECTION_INPUT -- requirements
Module: section_input

Interface
REQ-001 SHALL provide ports (name direction width meaning), with clock and reset first:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- usrt_pedge  in  1  one-clk strobe marking a USRT bit-clock rising edge
- size_flag  in  1  1 = 8 data bits, 0 = 7 data bits
- rts  in  1  request-to-send from the far-end transmitter; gates start detection
- rxd  in  1  serial data; idles high
- rd_ack  in  1  consumer accepts rx_data and clears the sticky flags
- rx_data  out  8  last accepted frame, LSB-first; bit 7 = 0 in 7-bit mode
- rx_valid  out  1  rx_data holds an unread frame
- frame_err  out  1  sticky: a stop bit was sampled low
- overrun  out  1  sticky: a good frame was dropped because rx_valid was still set
- busy  out  1  high while not in IDLE
- pattern_err  out  1  sticky pattern-check failure (see Configuration)

Function
REQ-002 SHALL sample rxd only on clk edges where usrt_pedge=1; all other cycles hold state.
REQ-003 SHALL implement FSM states IDLE, DATA, STOP1, STOP2.
REQ-004 IDLE->DATA on a sample with rts=1 and rxd=0 (start bit); latch size_flag and clear the bit counter and shift register.
REQ-005 SHALL ignore rxd=0 in IDLE while rts=0; rts falling mid-frame SHALL NOT abort the frame.
REQ-006 DATA: shift in one bit per sample, LSB first; after 8 samples (latched size=1) or 7 samples (latched size=0) go to STOP1.
REQ-007 STOP1: sample -> STOP2; a low sample records a pending frame error.
REQ-008 STOP2: sample -> IDLE; frame is good only if both stop samples are 1.
REQ-009 Good frame, rx_valid=0 or rd_ack=1 in the same cycle: load rx_data and set rx_valid=1 on the clk edge following the STOP2 sample (1-clk latency).
REQ-010 Good frame, rx_valid=1 and rd_ack=0: keep the old rx_data, set overrun=1, discard the new frame.
REQ-011 Bad frame: set frame_err=1, leave rx_data and rx_valid unchanged.
REQ-012 rd_ack=1 SHALL clear rx_valid, frame_err, overrun and pattern_err unless the same cycle sets them (set wins).
REQ-013 IDLE SHALL accept a start bit on the very next sample after STOP2, so back-to-back frames have no gap.
REQ-014 The bit counter SHALL be 4 bits and never exceed 8.
REQ-015 busy SHALL be combinational from state != IDLE.

Reset
REQ-016 rst=1 at a clk edge SHALL force IDLE and clear the counter, shift register, rx_data=0, rx_valid=0, frame_err=0, overrun=0, pattern_err=0 and the pattern history.
REQ-017 rst SHALL take priority over usrt_pedge and rd_ack; reset mid-frame abandons the frame with no flag set.

Configuration
REQ-018 Macro RX_PATTERN_CHECK_EN, when defined: every good frame's data bits (7 or 8 per latched size) SHALL be all-0 or all-1 and opposite to the previous good frame; any violation sets pattern_err. The first frame after reset checks uniformity only.
REQ-019 The pattern check SHALL also run on good frames dropped by overrun.
REQ-020 Macro RX_PATTERN_CHECK_EN, when undefined: pattern_err SHALL be tied 0 and no pattern logic synthesized; all other behaviour is identical.

Verification
REQ-021 rts=1, size=1, frame 0,(8x0),1,1 -> rx_data=0x00, rx_valid=1 one clk after the 2nd stop sample, frame_err=0.
REQ-022 rts=1, size=0, frame 0,(7x1),1,1 with no rd_ack between frames, then a second good frame -> rx_data=0x7F kept, overrun=1.
REQ-023 Frame 0,(8x1),0,1 -> frame_err=1, rx_valid unchanged; then rd_ack pulse -> frame_err=0.
REQ-024 rts=0 with rxd=0 for 12 samples -> state stays IDLE, busy=0; rts drops after the 3rd data bit -> frame completes normally.
REQ-025 rst asserted in DATA after 4 bits -> all outputs 0 next clk; the following clean frame 0xFF is received correctly.
REQ-026 With RX_PATTERN_CHECK_EN: frames 0x00, 0xFF, 0xFF -> pattern_err=1 after the third frame; frame 0x0F -> pattern_err=1.
